// File: rtl/fsm_step_pkg.sv
// Shared state encoding, widths and counter-width helper for the fsm_step_ctrl slice.
package fsm_step_pkg;

  localparam int X_W = 2;
  localparam int Y_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Bits needed for a counter that runs 0..n-1 (never fewer than one).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsm_step_ctrl_btn_debounce.sv
// Two-FF synchronizer followed by a stable-count debouncer; rise pulses once per
// accepted low-to-high transition of the debounced level.
module btn_debounce
  import fsm_step_pkg::*;
#(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], raw};
  end

  // Any sample that agrees with the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        rise  <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_step_ctrl.sv
// Step sequencer owning the state register of the EGO1 Mealy next-state block.
// Optional FSM_STEP_TRACE_EN adds an 8-bit history of the last four committed states.
module fsm_step_ctrl
  import fsm_step_pkg::*;
#(
  parameter int DEB_CYCLES    = 20,
  parameter int SETTLE_CYCLES = 2,
  parameter int AUTO_DIV      = 100,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [X_W-1:0]   x_in,
  input  logic             step_btn,
  input  logic             auto_en,
  input  logic [Y_W-1:0]   ny,
  input  logic             z,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             z_q,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             busy,
  output logic             step_done
`ifdef FSM_STEP_TRACE_EN
  ,
  output logic [7:0]       trace
`endif
);

  localparam int PW = cnt_w(AUTO_DIV);
  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam logic [PW-1:0] PRE_LAST    = PW'(AUTO_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [X_W-1:0] x_s1, x_s2;
  logic [1:0]     auto_s;
  logic           auto_sel;
  logic           btn_level, btn_rise;
  logic [PW-1:0]  pre_cnt;
  logic           tick, req;
  logic [SW-1:0]  settle_cnt;
  state_t         state, next_state;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (step_btn),
    .level (btn_level),
    .rise  (btn_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_s1   <= '0;
      x_s2   <= '0;
      auto_s <= '0;
    end else begin
      x_s1   <= x_in;
      x_s2   <= x_s1;
      auto_s <= {auto_s[0], auto_en};
    end
  end

  assign auto_sel = auto_s[1];

  // Prescaler only runs in auto mode so the first tick lands a full period after enabling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    pre_cnt <= '0;
    else if (!auto_sel)            pre_cnt <= '0;
    else if (pre_cnt == PRE_LAST)  pre_cnt <= '0;
    else                           pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = auto_sel && (pre_cnt == PRE_LAST);
  assign req  = auto_sel ? tick : (btn_rise && btn_level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Requests are only looked at in IDLE, so anything arriving mid-step is dropped.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) next_state = LOAD;
      end
      LOAD:    next_state = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                settle_cnt <= '0;
    else if (state == SETTLE)  settle_cnt <= settle_cnt + 1'b1;
    else                       settle_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      z_q       <= 1'b0;
      hit_cnt   <= '0;
      step_done <= 1'b0;
    end else begin
      step_done <= (state == COMMIT);
      if (state == LOAD) x <= x_s2;
      if (state == COMMIT) begin
        y   <= ny;
        z_q <= z;
        if (z && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
      end
    end
  end

`ifdef FSM_STEP_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                trace <= '0;
    else if (state == COMMIT)  trace <= {trace[5:0], ny};
  end
`endif

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Scoreboard bench for fsm_step_ctrl; the next-state block is modelled as ny=y+1, z=(y==3 && x==1).
module tb_fsm_step_ctrl;

  localparam int DEB     = 20;
  localparam int SETTLE  = 2;
  localparam int DIV     = 100;
  localparam int CNT_W   = 2;
  localparam int HIT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [1:0]       xv;
    logic [1:0]       yv;
    logic             zv;
    logic [CNT_W-1:0] hit;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       x_in = '0;
  logic             step_btn = 1'b0;
  logic             auto_en = 1'b0;
  logic [1:0]       nl_ny;
  logic             nl_z;
  logic [1:0]       x;
  logic [1:0]       y;
  logic             z_q;
  logic [CNT_W-1:0] hit_cnt;
  logic             busy;
  logic             step_done;
`ifdef FSM_STEP_TRACE_EN
  logic [7:0]       trace;
`endif

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   model_y = 0;
  int   model_hit = 0;
  int   dbusy = 23;

  fsm_step_ctrl #(
    .DEB_CYCLES    (DEB),
    .SETTLE_CYCLES (SETTLE),
    .AUTO_DIV      (DIV),
    .CNT_W         (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_in      (x_in),
    .step_btn  (step_btn),
    .auto_en   (auto_en),
    .ny        (nl_ny),
    .z         (nl_z),
    .x         (x),
    .y         (y),
    .z_q       (z_q),
    .hit_cnt   (hit_cnt),
    .busy      (busy),
    .step_done (step_done)
`ifdef FSM_STEP_TRACE_EN
    ,
    .trace     (trace)
`endif
  );

  assign nl_ny = y + 2'd1;
  assign nl_z  = (y == 2'b11) && (x == 2'b01);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t observed();
    exp_t o;
    o.xv  = x;
    o.yv  = y;
    o.zv  = z_q;
    o.hit = hit_cnt;
    return o;
  endfunction

  // Independent model of one commit, pushed when the request is issued.
  task automatic push_step(input logic [1:0] xv);
    exp_t e;
    e.xv = xv;
    e.zv = (model_y == 3) && (xv == 2'b01);
    model_y = (model_y + 1) % 4;
    e.yv = 2'(model_y);
    if (e.zv && model_hit < HIT_MAX) model_hit++;
    e.hit = CNT_W'(model_hit);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step_btn = 1'b0;
    auto_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_y = 0;
    model_hit = 0;
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_step(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = step_done;
    end
  endtask

  task automatic count_steps(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (step_done) n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({x, y, z_q} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_xyz: got %b want 00000", {x, y, z_q});
    end
    tests++;
    if (hit_cnt !== '0) begin
      fails++;
      $display("[TB] FAIL reset_hit: got %0d want 0", hit_cnt);
    end
    tests++;
    if ({busy, step_done} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b want 00", {busy, step_done});
    end
`ifdef FSM_STEP_TRACE_EN
    tests++;
    if (trace !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_trace: got %b want 00000000", trace);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_step();
    int c0, c_load, n;
    bit seen;
    exp_t e;
    x_in = 2'b10;
    repeat (5) @(negedge clk);
    push_step(2'b10);
    step_btn = 1'b1;
    c0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    c_load = cyc;
    dbusy = c_load - c0;
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL first_busy: busy never rose within 100 cycles, want 1");
    end
    @(negedge clk);
    tests++;
    if (x !== 2'b10) begin
      fails++;
      $display("[TB] FAIL first_x_after_load: got %b want 10", x);
    end
    repeat (SETTLE) @(negedge clk);
    tests++;
    if (y !== 2'b00 || step_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL first_y_early: got y=%b done=%b want y=00 done=0", y, step_done);
    end
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (step_done !== 1'b1 || observed() !== e) begin
      fails++;
      $display("[TB] FAIL first_commit at %0d cycles after load: got %b done=%b want %b done=1",
               cyc - c_load, observed(), step_done, e);
    end
    @(negedge clk);
    tests++;
    if ({step_done, busy} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL first_pulse_width: got done,busy=%b want 00", {step_done, busy});
    end
    step_btn = 1'b0;
    count_steps(40, n);
    tests++;
    if (n != 0) begin
      fails++;
      $display("[TB] FAIL first_release: got %0d extra steps want 0", n);
    end
  endtask

  task automatic test_button_steps();
    bit ok;
    int n;
    exp_t e;
    do_reset();
    x_in = 2'b01;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      push_step(2'b01);
      step_btn = 1'b1;
      wait_step(80, ok);
      e = sb.pop_front();
      tests++;
      if (!ok || observed() !== e) begin
        fails++;
        $display("[TB] FAIL button_step%0d: got %b seen=%0b want %b", k, observed(), ok, e);
      end
      step_btn = 1'b0;
      count_steps(30, n);
      tests++;
      if (n != 0) begin
        fails++;
        $display("[TB] FAIL button_release%0d: got %0d steps want 0", k, n);
      end
    end
    tests++;
    if (hit_cnt !== CNT_W'(1) || z_q !== 1'b1) begin
      fails++;
      $display("[TB] FAIL button_hits: got hit=%0d z_q=%b want hit=1 z_q=1", hit_cnt, z_q);
    end
`ifdef FSM_STEP_TRACE_EN
    tests++;
    if (trace !== 8'b01101100) begin
      fails++;
      $display("[TB] FAIL trace_history: got %b want 01101100", trace);
    end
`endif
  endtask

  task automatic test_bounce();
    bit ok;
    int n;
    exp_t e;
    push_step(2'b01);
    for (int i = 0; i < 10; i++) begin
      step_btn = (i % 2 == 0);
      @(negedge clk);
    end
    step_btn = 1'b1;
    wait_step(80, ok);
    e = sb.pop_front();
    tests++;
    if (!ok || observed() !== e) begin
      fails++;
      $display("[TB] FAIL bounce_step: got %b seen=%0b want %b", observed(), ok, e);
    end
    count_steps(40, n);
    step_btn = 1'b0;
    begin
      int m;
      count_steps(30, m);
      n += m;
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("[TB] FAIL bounce_extra: got %0d extra steps want 0", n);
    end
  endtask

  task automatic test_auto();
    bit ok;
    int n, t0;
    exp_t e;
    x_in = 2'b11;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 11; k++) push_step(2'b11);
    auto_en = 1'b1;
    t0 = 0;
    for (int k = 0; k < 11; k++) begin
      if (k == 3) step_btn = 1'b1;
      if (k == 6) step_btn = 1'b0;
      wait_step((k == 0) ? 300 : 150, ok);
      if (k == 0) t0 = cyc;
      e = sb.pop_front();
      tests++;
      if (!ok || observed() !== e) begin
        fails++;
        $display("[TB] FAIL auto_step%0d: got %b seen=%0b want %b", k, observed(), ok, e);
      end
    end
    tests++;
    if (cyc - t0 != 10 * DIV) begin
      fails++;
      $display("[TB] FAIL auto_period: got %0d cycles for 10 commits want %0d", cyc - t0, 10 * DIV);
    end
    auto_en = 1'b0;
    count_steps(150, n);
    tests++;
    if (n != 0) begin
      fails++;
      $display("[TB] FAIL auto_stop: got %0d steps after disable want 0", n);
    end
  endtask

  // A tick starts a step; auto is then dropped so a button edge lands in SETTLE.
  task automatic test_drop_busy();
    bit ok;
    int n, q, l, p;
    exp_t e;
    x_in = 2'b10;
    repeat (5) @(negedge clk);
    push_step(2'b10);
    push_step(2'b10);
    auto_en = 1'b1;
    wait_step(300, ok);
    q = cyc;
    e = sb.pop_front();
    tests++;
    if (!ok || observed() !== e) begin
      fails++;
      $display("[TB] FAIL drop_first: got %b seen=%0b want %b", observed(), ok, e);
    end
    l = q + DIV - (SETTLE + 2);
    p = l + 3 - dbusy;
    for (int i = 0; i < 200 && cyc < p; i++) @(negedge clk);
    step_btn = 1'b1;
    for (int i = 0; i < 200 && cyc < l; i++) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL drop_load: got busy=%b at predicted tick step want 1", busy);
    end
    auto_en = 1'b0;
    wait_step(50, ok);
    e = sb.pop_front();
    tests++;
    if (!ok || observed() !== e) begin
      fails++;
      $display("[TB] FAIL drop_commit: got %b seen=%0b want %b", observed(), ok, e);
    end
    count_steps(150, n);
    step_btn = 1'b0;
    tests++;
    if (n != 0) begin
      fails++;
      $display("[TB] FAIL drop_queued: got %0d extra steps want 0", n);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_mid_step();
    bit seen;
    int n;
    x_in = 2'b01;
    repeat (5) @(negedge clk);
    step_btn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    @(negedge clk);
    rst_n = 1'b0;
    step_btn = 1'b0;
    #1;
    tests++;
    if (!seen || y !== 2'b00 || hit_cnt !== '0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_reset: got seen=%0b y=%b hit=%0d busy=%b want 1 00 0 0",
               seen, y, hit_cnt, busy);
    end
    model_y = 0;
    model_hit = 0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    count_steps(60, n);
    tests++;
    if (n != 0 || y !== 2'b00) begin
      fails++;
      $display("[TB] FAIL abort_no_done: got %0d steps y=%b want 0 steps y=00", n, y);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int n;
    exp_t e;
    do_reset();
    x_in = 2'b01;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 20; k++) push_step(2'b01);
    auto_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_step((k == 0) ? 300 : 150, ok);
      e = sb.pop_front();
      tests++;
      if (!ok || observed() !== e) begin
        fails++;
        $display("[TB] FAIL sat_step%0d: got %b seen=%0b want %b", k, observed(), ok, e);
      end
    end
    auto_en = 1'b0;
    count_steps(150, n);
    tests++;
    if (n != 0 || hit_cnt !== CNT_W'(HIT_MAX)) begin
      fails++;
      $display("[TB] FAIL sat_final: got steps=%0d hit=%0d want 0 and %0d", n, hit_cnt, HIT_MAX);
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_button_steps();
    test_bounce();
    test_auto();
    test_drop_busy();
    test_reset_mid_step();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
